// File: rtl/drbg_seq_pkg.sv
// Shared DRBG sequence beacon definitions: FSM encodings, sync/CRC constants and the CRC-8 step.
// Also imported by the descrambler-side extractor so both ends agree on the framing.
package drbg_seq_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_WAIT_LINE   = 3'd1;
    localparam logic [2:0] ST_WAIT_OFFSET = 3'd2;
    localparam logic [2:0] ST_PREAMBLE    = 3'd3;
    localparam logic [2:0] ST_PAYLOAD     = 3'd4;
    localparam logic [2:0] ST_CRC         = 3'd5;
    localparam logic [2:0] ST_FINISH      = 3'd6;

    localparam logic [7:0] SEQ_PREAMBLE = 8'hAC;
    localparam logic [7:0] CRC8_POLY    = 8'h07;

    localparam int PREAMBLE_BITS     = 8;
    localparam int PAYLOAD_BITS      = 32;
    localparam int CRC_BITS          = 8;
    localparam int BEACON_BITS_NOCRC = PREAMBLE_BITS + PAYLOAD_BITS;
    localparam int BEACON_BITS_CRC   = PREAMBLE_BITS + PAYLOAD_BITS + CRC_BITS;

    // One MSB-first message bit into a non-reflected CRC-8 register.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/drbg_sequence_emitter_crc8.sv
// Bit-serial CRC-8 (poly 0x07, init 0, no reflection, no final XOR) over the beacon payload.
module drbg_seq_crc8
    import drbg_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (bit_valid) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/drbg_sequence_emitter.sv
// Serialises a per-frame snapshot of the DRBG sequence count into one blanking line as luma bits.
// Define DRBG_SEQ_EMIT_CRC_EN to append a CRC-8 after the 32-bit payload (48-bit beacon instead of 40).
module drbg_sequence_emitter
    import drbg_seq_pkg::*;
#(
    parameter logic [10:0] TX_LINE      = 11'd10,
    parameter logic [10:0] PIXEL_OFFSET = 11'd16,
    parameter int          BIT_PIXELS   = 4,
    parameter logic [7:0]  PREAMBLE     = SEQ_PREAMBLE,
    parameter logic [7:0]  LEVEL_HIGH   = 8'd235,
    parameter logic [7:0]  LEVEL_LOW    = 8'd16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        pixel_en,
    input  logic [31:0] sequence_value,
    output logic        pixel_override,
    output logic [7:0]  pixel_level,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [31:0] tx_sequence
);

    localparam int SW = (BIT_PIXELS > 1) ? $clog2(BIT_PIXELS) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(BIT_PIXELS - 1);

    logic [2:0]    state_q, state_d;
    logic [10:0]   line_cnt_q, line_cnt_d;
    logic [10:0]   pix_cnt_q, pix_cnt_d;
    logic [SW-1:0] sub_cnt_q, sub_cnt_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [31:0]   tx_sequence_q, tx_sequence_d;
    logic          override_q, override_d;
    logic [7:0]    level_q, level_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [10:0]   slot;
    logic [10:0]   line_next;
    logic          in_beacon;
    logic          emit;
    logic          emit_bit;
    logic [2:0]    emit_state;
    logic [4:0]    emit_idx;
    logic [SW-1:0] emit_sub;
    logic [4:0]    last_idx;
    logic [2:0]    after_state;

`ifdef DRBG_SEQ_EMIT_CRC_EN
    logic          crc_clear;
    logic          crc_valid;
    logic          crc_bit;
    logic [7:0]    crc_value;

    drbg_seq_crc8 u_crc8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (crc_clear),
        .bit_valid (crc_valid),
        .bit_in    (crc_bit),
        .crc       (crc_value)
    );
`endif

    always_comb begin
        state_d       = state_q;
        line_cnt_d    = line_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        sub_cnt_d     = sub_cnt_q;
        bit_idx_d     = bit_idx_q;
        tx_sequence_d = tx_sequence_q;
        override_d    = override_q;
        level_d       = level_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        emit          = 1'b0;
        emit_bit      = 1'b0;
        emit_state    = state_q;
        emit_idx      = bit_idx_q;
        emit_sub      = sub_cnt_q;
        last_idx      = 5'd7;
        after_state   = ST_FINISH;
`ifdef DRBG_SEQ_EMIT_CRC_EN
        crc_clear     = 1'b0;
        crc_valid     = 1'b0;
        crc_bit       = 1'b0;
`endif

        // A strobe coinciding with line_start is slot 0 of the new line.
        slot      = line_start ? 11'd0 : pix_cnt_q;
        line_next = (line_cnt_q == 11'h7FF) ? line_cnt_q : line_cnt_q + 11'd1;
        in_beacon = (state_q == ST_PREAMBLE) || (state_q == ST_PAYLOAD) || (state_q == ST_CRC);

        if (line_start) begin
            pix_cnt_d = pixel_en ? 11'd1 : 11'd0;
        end else if (pixel_en && pix_cnt_q != 11'h7FF) begin
            pix_cnt_d = pix_cnt_q + 11'd1;
        end

        if (frame_start) begin
            line_cnt_d = 11'd0;
        end else if (line_start) begin
            line_cnt_d = line_next;
        end

        if (frame_start) begin
            tx_sequence_d = sequence_value;
            state_d       = (line_start && TX_LINE == 11'd0) ? ST_WAIT_OFFSET : ST_WAIT_LINE;
            override_d    = 1'b0;
            busy_d        = 1'b0;
            level_d       = LEVEL_LOW;
            sub_cnt_d     = '0;
            bit_idx_d     = 5'd0;
        end else if (line_start && (in_beacon || state_q == ST_WAIT_OFFSET)) begin
            // Line ended before the beacon fitted: give up for this frame.
            state_d    = ST_IDLE;
            override_d = 1'b0;
            busy_d     = 1'b0;
            level_d    = LEVEL_LOW;
            sub_cnt_d  = '0;
            bit_idx_d  = 5'd0;
        end else if (line_start && state_q == ST_WAIT_LINE && line_next == TX_LINE) begin
            state_d = ST_WAIT_OFFSET;
        end

        if (pixel_en) begin
            if (state_d == ST_WAIT_OFFSET && slot == PIXEL_OFFSET) begin
                emit       = 1'b1;
                emit_state = ST_PREAMBLE;
                emit_idx   = 5'd0;
                emit_sub   = '0;
            end else if (in_beacon && !frame_start && !line_start) begin
                emit = 1'b1;
            end else if (state_q == ST_FINISH && !frame_start) begin
                state_d    = ST_IDLE;
                override_d = 1'b0;
                busy_d     = 1'b0;
                level_d    = LEVEL_LOW;
                done_d     = 1'b1;
            end
        end

        if (emit) begin
            case (emit_state)
                ST_PREAMBLE: begin
                    emit_bit    = PREAMBLE[~emit_idx[2:0]];
                    last_idx    = 5'd7;
                    after_state = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    emit_bit    = tx_sequence_q[~emit_idx];
                    last_idx    = 5'd31;
`ifdef DRBG_SEQ_EMIT_CRC_EN
                    after_state = ST_CRC;
                    crc_valid   = (emit_sub == '0);
                    crc_bit     = emit_bit;
`else
                    after_state = ST_FINISH;
`endif
                end
`ifdef DRBG_SEQ_EMIT_CRC_EN
                ST_CRC: begin
                    emit_bit    = crc_value[~emit_idx[2:0]];
                    last_idx    = 5'd7;
                    after_state = ST_FINISH;
                end
`endif
                default: begin
                    emit_bit    = 1'b0;
                    last_idx    = 5'd7;
                    after_state = ST_FINISH;
                end
            endcase

            override_d = 1'b1;
            busy_d     = 1'b1;
            level_d    = emit_bit ? LEVEL_HIGH : LEVEL_LOW;
            state_d    = emit_state;
            bit_idx_d  = emit_idx;
            sub_cnt_d  = emit_sub + SW'(1);

            if (emit_sub == SUB_LAST) begin
                sub_cnt_d = '0;
                if (emit_idx == last_idx) begin
                    bit_idx_d = 5'd0;
                    state_d   = after_state;
`ifdef DRBG_SEQ_EMIT_CRC_EN
                    crc_clear = (after_state == ST_PAYLOAD);
`endif
                end else begin
                    bit_idx_d = emit_idx + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            line_cnt_q    <= 11'd0;
            pix_cnt_q     <= 11'd0;
            sub_cnt_q     <= '0;
            bit_idx_q     <= 5'd0;
            tx_sequence_q <= 32'd0;
            override_q    <= 1'b0;
            level_q       <= LEVEL_LOW;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_cnt_q    <= line_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            sub_cnt_q     <= sub_cnt_d;
            bit_idx_q     <= bit_idx_d;
            tx_sequence_q <= tx_sequence_d;
            override_q    <= override_d;
            level_q       <= level_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign pixel_override = override_q;
    assign pixel_level    = level_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;
    assign tx_sequence    = tx_sequence_q;

endmodule

// File: tb/tb_drbg_sequence_emitter.sv
// Directed bench for drbg_sequence_emitter: nominal beacon, snapshot, aborts, pixel_en gaps, reset.
// Honours DRBG_SEQ_EMIT_CRC_EN so the expected beacon length follows the build.
module tb_drbg_sequence_emitter;

`ifdef DRBG_SEQ_EMIT_CRC_EN
    localparam int BEACON_BITS = 48;
`else
    localparam int BEACON_BITS = 40;
`endif
    localparam int FIRST_SLOT = 16;
    localparam int BITP       = 4;
    localparam int END_SLOT   = FIRST_SLOT + BITP * BEACON_BITS;
    localparam int LINE_SLOTS = 220;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        line_start;
    logic        pixel_en;
    logic [31:0] sequence_value;
    logic        pixel_override;
    logic [7:0]  pixel_level;
    logic        tx_busy;
    logic        tx_done;
    logic [31:0] tx_sequence;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    drbg_sequence_emitter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .line_start     (line_start),
        .pixel_en       (pixel_en),
        .sequence_value (sequence_value),
        .pixel_override (pixel_override),
        .pixel_level    (pixel_level),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_sequence    (tx_sequence)
    );

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic fs, input logic ls, input logic pe);
        @(negedge clk);
        frame_start = fs;
        line_start  = ls;
        pixel_en    = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic lead_lines();
        for (int l = 1; l < 10; l++) begin
            cyc(1'b0, 1'b1, 1'b1);
            repeat (3) cyc(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic start_frame(input logic [31:0] seq);
        sequence_value = seq;
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        lead_lines();
    endtask

    // Runs one line slot by slot, checking each strobe (and each gap cycle) against the expected beacon.
    task automatic beacon_line(input string tag, input logic expect_beacon, input logic [31:0] seq,
                               input logic [7:0] crc, input int gap, input int stop_slot,
                               input int chg_slot, input logic [31:0] chg_val);
        logic [47:0] word;
        logic        exp_ov;
        logic        exp_done;
        logic [7:0]  exp_lvl;
        word = {8'hAC, seq, crc};
        for (int p = 0; p < LINE_SLOTS; p++) begin
            if (p == stop_slot) return;
            if (p == chg_slot) sequence_value = chg_val;
            cyc(1'b0, p == 0, 1'b1);
            exp_ov   = expect_beacon && p >= FIRST_SLOT && p < END_SLOT;
            exp_done = expect_beacon && p == END_SLOT;
            exp_lvl  = 8'd16;
            if (exp_ov && word[47 - (p - FIRST_SLOT) / BITP]) exp_lvl = 8'd235;
            for (int g = 0; g <= gap; g++) begin
                if (g > 0) begin
                    cyc(1'b0, 1'b0, 1'b0);
                    exp_done = 1'b0;
                end
                vectors++;
                if (pixel_override !== exp_ov) begin
                    miscompares++;
                    $display("[TB] FAIL %s override slot %0d gap %0d: got %b want %b", tag, p, g, pixel_override, exp_ov);
                end
                vectors++;
                if (tx_busy !== exp_ov) begin
                    miscompares++;
                    $display("[TB] FAIL %s tx_busy slot %0d gap %0d: got %b want %b", tag, p, g, tx_busy, exp_ov);
                end
                vectors++;
                if (pixel_level !== exp_lvl) begin
                    miscompares++;
                    $display("[TB] FAIL %s level slot %0d gap %0d: got %0d want %0d", tag, p, g, pixel_level, exp_lvl);
                end
                vectors++;
                if (tx_done !== exp_done) begin
                    miscompares++;
                    $display("[TB] FAIL %s tx_done slot %0d gap %0d: got %b want %b", tag, p, g, tx_done, exp_done);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        frame_start    = 1'b0;
        line_start     = 1'b0;
        pixel_en       = 1'b0;
        sequence_value = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (pixel_override !== 1'b0) begin miscompares++; $display("[TB] FAIL reset override: got %b want 0", pixel_override); end
        vectors++;
        if (pixel_level !== 8'd16) begin miscompares++; $display("[TB] FAIL reset level: got %0d want 16", pixel_level); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset tx_busy: got %b want 0", tx_busy); end
        vectors++;
        if (tx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset tx_done: got %b want 0", tx_done); end
        vectors++;
        if (tx_sequence !== 32'h0) begin miscompares++; $display("[TB] FAIL reset tx_sequence: got %h want 0", tx_sequence); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_nominal();
        start_frame(32'h0000_0001);
        vectors++;
        if (tx_sequence !== 32'h1) begin miscompares++; $display("[TB] FAIL nominal tx_sequence: got %h want 1", tx_sequence); end
        beacon_line("nominal", 1'b1, 32'h1, 8'h07, 0, -1, -1, 32'h0);
        beacon_line("nominal_line11", 1'b0, 32'h1, 8'h07, 0, -1, -1, 32'h0);
    endtask

    task automatic test_snapshot();
        sequence_value = 32'd5;
        cyc(1'b1, 1'b1, 1'b1);
        sequence_value = 32'd6;
        vectors++;
        if (tx_sequence !== 32'd5) begin miscompares++; $display("[TB] FAIL snapshot tx_sequence: got %0d want 5", tx_sequence); end
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        lead_lines();
        beacon_line("snapshot", 1'b1, 32'd5, 8'h1B, 0, -1, 60, 32'd7);
        vectors++;
        if (tx_sequence !== 32'd5) begin miscompares++; $display("[TB] FAIL snapshot hold: got %0d want 5", tx_sequence); end
    endtask

    task automatic test_pixel_gaps();
        start_frame(32'h0000_0001);
        beacon_line("gaps", 1'b1, 32'h1, 8'h07, 2, -1, -1, 32'h0);
    endtask

    task automatic test_abort_frame();
        start_frame(32'h0000_0001);
        beacon_line("abort_pre", 1'b1, 32'h1, 8'h07, 0, 100, -1, 32'h0);
        sequence_value = 32'd2;
        cyc(1'b1, 1'b1, 1'b1);
        vectors++;
        if (pixel_override !== 1'b0) begin miscompares++; $display("[TB] FAIL abort override: got %b want 0", pixel_override); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort tx_busy: got %b want 0", tx_busy); end
        vectors++;
        if (tx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort tx_done: got %b want 0", tx_done); end
        vectors++;
        if (tx_sequence !== 32'd2) begin miscompares++; $display("[TB] FAIL abort tx_sequence: got %0d want 2", tx_sequence); end
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        lead_lines();
        beacon_line("abort_next", 1'b1, 32'd2, 8'h0E, 0, -1, -1, 32'h0);
    endtask

    task automatic test_short_line();
        start_frame(32'h0000_0001);
        beacon_line("short_pre", 1'b1, 32'h1, 8'h07, 0, 120, -1, 32'h0);
        cyc(1'b0, 1'b1, 1'b1);
        vectors++;
        if (pixel_override !== 1'b0) begin miscompares++; $display("[TB] FAIL short override: got %b want 0", pixel_override); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL short tx_busy: got %b want 0", tx_busy); end
        vectors++;
        if (pixel_level !== 8'd16) begin miscompares++; $display("[TB] FAIL short level: got %0d want 16", pixel_level); end
        for (int p = 1; p < LINE_SLOTS; p++) begin
            cyc(1'b0, 1'b0, 1'b1);
            vectors++;
            if (pixel_override !== 1'b0 || tx_done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL short line11 slot %0d: got override %b done %b want 0 0", p, pixel_override, tx_done);
            end
        end
        beacon_line("short_line12", 1'b0, 32'h1, 8'h07, 0, -1, -1, 32'h0);
    endtask

    task automatic test_reset_mid();
        start_frame(32'h0000_0001);
        beacon_line("rst_pre", 1'b1, 32'h1, 8'h07, 0, 60, -1, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (pixel_override !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid override: got %b want 0", pixel_override); end
        vectors++;
        if (pixel_level !== 8'd16) begin miscompares++; $display("[TB] FAIL rst_mid level: got %0d want 16", pixel_level); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid tx_busy: got %b want 0", tx_busy); end
        vectors++;
        if (tx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid tx_done: got %b want 0", tx_done); end
        vectors++;
        if (tx_sequence !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid tx_sequence: got %h want 0", tx_sequence); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int l = 0; l < 12; l++) begin
            beacon_line("rst_silent", 1'b0, 32'h1, 8'h07, 0, -1, -1, 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_nominal();
        test_snapshot();
        test_pixel_gaps();
        test_abort_frame();
        test_short_line();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
